// File: rtl/vga_capture_if.sv
// rtl/vga_capture_if.sv - pin input and recovered-video outputs of vga_capture
//
// Ports (slave = capture block, master = stream source / consumer):
//   vga_in     8   {hsync, B0, G0, R0, vsync, B1, G1, R1}, syncs active-low
//   pix_x      10  x of the current output sample
//   pix_y      10  y of the current output sample
//   pix_valid  1   locked and inside the active area
//   rgb        6   {R[1:0], G[1:0], B[1:0]} of the current sample
//   locked     1   timing matches parameters
//   h_period   11  clocks between the last two hsync falls (saturating)
//   v_period   11  lines between the last two vsync falls (saturating)
//   frame_sum  16  checksum of the last completed frame
//   sum_valid  1   one-cycle pulse when frame_sum updates
//   blank_err  1   sticky: nonzero RGB seen in blanking while locked
interface vga_capture_if;
   logic [7:0]  vga_in;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_valid;
   logic [5:0]  rgb;
   logic        locked;
   logic [10:0] h_period;
   logic [10:0] v_period;
   logic [15:0] frame_sum;
   logic        sum_valid;
   logic        blank_err;

   modport master (
      output vga_in,
      input  pix_x, pix_y, pix_valid, rgb, locked,
      input  h_period, v_period, frame_sum, sum_valid, blank_err
   );

   modport slave (
      input  vga_in,
      output pix_x, pix_y, pix_valid, rgb, locked,
      output h_period, v_period, frame_sum, sum_valid, blank_err
   );
endinterface

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - TinyVGA PMOD receiver: coordinate recovery, timing lock, frame checksum
//
// Ports:
//   clk    pixel clock, one pin sample per cycle
//   rst_n  synchronous, active-low reset
//   vif    vga_capture_if.slave: vga_in in, recovered video and status out
//
// Stage 0 registers the pins into vq and detects sync falls against the
// previous sample; stage 1 registers coordinates, colour and pix_valid.
module vga_capture #(
   parameter int H_DISPLAY    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_TOTAL      = 800,
   parameter int V_DISPLAY    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_TOTAL      = 525
) (
   input  logic          clk,
   input  logic          rst_n,
   vga_capture_if.slave  vif
);

   typedef enum logic [1:0] {SEARCH, H_OK, LOCKED} lock_state_t;

   lock_state_t state_q, state_d;

   logic [7:0]  vq;
   logic        hs_prev, vs_prev;
   logic        hs_fall, vs_fall;
   logic [9:0]  x_cnt, y_cnt, x_cur, y_cur;
   logic        x_wrap;
   logic [5:0]  rgb0;
   logic        active0;
   logic [10:0] hc, vc, h_meas;
   logic        h_match, v_match, timeout, h_good;
   logic [15:0] acc;

   logic [9:0]  pix_x_q, pix_y_q;
   logic        pix_valid_q;
   logic [5:0]  rgb_q;
   logic [10:0] h_period_q, v_period_q;
   logic [15:0] frame_sum_q;
   logic        sum_valid_q, blank_err_q;

   assign hs_fall = hs_prev & ~vq[7];
   assign vs_fall = vs_prev & ~vq[3];

   // Pin order is {hs, B0, G0, R0, vs, B1, G1, R1}; regroup as {R1,R0,G1,G0,B1,B0}.
   assign rgb0 = {vq[0], vq[4], vq[1], vq[5], vq[2], vq[6]};

   // A sync fall re-anchors the free-running counters to the known edge position.
   assign x_cur   = hs_fall ? 10'(H_SYNC_START) : x_cnt;
   assign y_cur   = vs_fall ? 10'(V_SYNC_START) : y_cnt;
   assign x_wrap  = (x_cur == 10'(H_TOTAL - 1));
   assign active0 = (x_cur < 10'(H_DISPLAY)) && (y_cur < 10'(V_DISPLAY));

   // Period of the line that ends with this hs_fall, saturating.
   assign h_meas  = (hc == 11'h7FF) ? 11'h7FF : hc + 11'd1;
   assign h_match = (h_meas == 11'(H_TOTAL));
   assign v_match = (vc == 11'(V_TOTAL));
   assign timeout = (hc >= 11'(2 * H_TOTAL));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= SEARCH;
      else        state_q <= state_d;
   end

   // A bad line or lost hsync always wins; otherwise climb one step per good event.
   always_comb begin
      state_d = state_q;
      if ((hs_fall && !h_match) || timeout) begin
         state_d = SEARCH;
      end else begin
         case (state_q)
            SEARCH:  if (hs_fall && h_good)     state_d = H_OK;
            H_OK:    if (vs_fall && v_match)    state_d = LOCKED;
            LOCKED:  if (vs_fall && !v_match)   state_d = H_OK;
            default:                            state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vq          <= 8'hFF;
         hs_prev     <= 1'b1;
         vs_prev     <= 1'b1;
         x_cnt       <= '0;
         y_cnt       <= '0;
         hc          <= '0;
         vc          <= '0;
         h_good      <= 1'b0;
         acc         <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_valid_q <= 1'b0;
         rgb_q       <= '0;
         h_period_q  <= '0;
         v_period_q  <= '0;
         frame_sum_q <= '0;
         sum_valid_q <= 1'b0;
         blank_err_q <= 1'b0;
      end else begin
         vq      <= vif.vga_in;
         hs_prev <= vq[7];
         vs_prev <= vq[3];

         x_cnt <= x_wrap ? 10'd0 : x_cur + 10'd1;
         // Wrap increment applies on top of a same-cycle vsync reload.
         if (x_wrap)
            y_cnt <= (y_cur == 10'(V_TOTAL - 1)) ? 10'd0 : y_cur + 10'd1;
         else if (vs_fall)
            y_cnt <= y_cur;

         pix_x_q     <= x_cur;
         pix_y_q     <= y_cur;
         rgb_q       <= rgb0;
         pix_valid_q <= (state_q == LOCKED) && active0;
         if ((state_q == LOCKED) && !active0 && (rgb0 != 6'd0))
            blank_err_q <= 1'b1;

         if (hs_fall) begin
            hc         <= '0;
            h_period_q <= h_meas;
         end else if (hc != 11'h7FF) begin
            hc <= hc + 11'd1;
         end

         if (vs_fall) begin
            v_period_q <= vc;
            vc         <= '0;
         end else if (hs_fall && (vc != 11'h7FF)) begin
            vc <= vc + 11'd1;
         end

         // h_good remembers that the previous line was already the right length.
         if (timeout || (hs_fall && !h_match)) h_good <= 1'b0;
         else if (hs_fall)                     h_good <= 1'b1;

         sum_valid_q <= 1'b0;
         if (vs_fall) begin
            acc <= '0;
            if (state_q == LOCKED) begin
               frame_sum_q <= acc;
               sum_valid_q <= 1'b1;
            end
         end else if (pix_valid_q) begin
            acc <= {acc[14:0], acc[15]} ^ {10'b0, rgb_q};
         end
      end
   end

   assign vif.pix_x     = pix_x_q;
   assign vif.pix_y     = pix_y_q;
   assign vif.pix_valid = pix_valid_q;
   assign vif.rgb       = rgb_q;
   assign vif.locked    = (state_q == LOCKED);
   assign vif.h_period  = h_period_q;
   assign vif.v_period  = v_period_q;
   assign vif.frame_sum = frame_sum_q;
   assign vif.sum_valid = sum_valid_q;
   assign vif.blank_err = blank_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - self-checking bench for vga_capture on a reduced 16x12 raster
module tb_vga_capture;
   localparam int HD  = 8;
   localparam int HSS = 10;
   localparam int HT  = 16;
   localparam int VD  = 6;
   localparam int VSS = 8;
   localparam int VT  = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vga_capture_if vif();

   vga_capture #(
      .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
      .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .vif(vif)
   );

   typedef struct {
      logic [5:0]  act;
      bit          chk_pix;
      bit          exp_locked;
      int          exp_h;
      int          exp_v;
      int          exp_pulses;
      logic [15:0] exp_sum;
   } frame_vec_t;

   frame_vec_t vecs[5];

   int         n_checks  = 0;
   int         n_errors  = 0;
   int         pulse_cnt = 0;
   logic [5:0] g_act     = 6'd0;
   logic [5:0] g_inj_rgb = 6'd0;
   int         g_inj_x   = -1;
   int         g_inj_y   = -1;
   bit         g_hs_force = 1'b0;
   bit         g_chk_pix  = 1'b0;
   int         hx[3];
   int         hy[3];
   logic [5:0] hr[3];

   function automatic logic [15:0] sum_model(input logic [5:0] v);
      logic [15:0] a;
      a = 16'd0;
      for (int i = 0; i < HD * VD; i++)
         a = {a[14:0], a[15]} ^ {10'b0, v};
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one generator pixel just after the edge, then sample outputs at the negedge.
   task automatic gen_step(input int x, input int y);
      logic [5:0] c;
      logic       hs, vs;
      if (x < HD && y < VD)                c = g_act;
      else if (x == g_inj_x && y == g_inj_y) c = g_inj_rgb;
      else                                 c = 6'd0;
      hs = g_hs_force || !(x >= HSS && x < HSS + 2);
      vs = !(y >= VSS && y < VSS + 2);
      @(posedge clk);
      #1;
      vif.vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
      for (int i = 2; i > 0; i--) begin
         hx[i] = hx[i-1];
         hy[i] = hy[i-1];
         hr[i] = hr[i-1];
      end
      hx[0] = x;
      hy[0] = y;
      hr[0] = c;
      @(negedge clk);
      if (vif.sum_valid) pulse_cnt++;
      if (g_chk_pix) begin
         chk("pix_x", vif.pix_x, hx[2]);
         chk("pix_y", vif.pix_y, hy[2]);
         chk("pix_valid", vif.pix_valid, (hx[2] < HD && hy[2] < VD));
         chk("rgb", vif.rgb, hr[2]);
      end
   endtask

   task automatic run_frame();
      for (int y = 0; y < VT; y++)
         for (int x = 0; x < HT; x++)
            gen_step(x, y);
   endtask

   task automatic check_reset_outs();
      chk("rst_pix_x", vif.pix_x, 0);
      chk("rst_pix_y", vif.pix_y, 0);
      chk("rst_pix_valid", vif.pix_valid, 0);
      chk("rst_rgb", vif.rgb, 0);
      chk("rst_locked", vif.locked, 0);
      chk("rst_h_period", vif.h_period, 0);
      chk("rst_v_period", vif.v_period, 0);
      chk("rst_frame_sum", vif.frame_sum, 0);
      chk("rst_sum_valid", vif.sum_valid, 0);
      chk("rst_blank_err", vif.blank_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{act: 6'h3F, chk_pix: 0, exp_locked: 0, exp_h: HT, exp_v: 8,  exp_pulses: 0, exp_sum: 16'h0};
      vecs[1] = '{act: 6'h3F, chk_pix: 0, exp_locked: 1, exp_h: HT, exp_v: VT, exp_pulses: 0, exp_sum: 16'h0};
      vecs[2] = '{act: 6'h3F, chk_pix: 1, exp_locked: 1, exp_h: HT, exp_v: VT, exp_pulses: 1, exp_sum: sum_model(6'h3F)};
      vecs[3] = '{act: 6'h00, chk_pix: 1, exp_locked: 1, exp_h: HT, exp_v: VT, exp_pulses: 1, exp_sum: 16'h0};
      vecs[4] = '{act: 6'h15, chk_pix: 1, exp_locked: 1, exp_h: HT, exp_v: VT, exp_pulses: 1, exp_sum: sum_model(6'h15)};
      for (int i = 0; i < 3; i++) begin
         hx[i] = 0;
         hy[i] = 0;
         hr[i] = 6'd0;
      end

      rst_n = 1'b0;
      vif.vga_in = 8'hFF;
      repeat (4) @(negedge clk);
      check_reset_outs();
      rst_n = 1'b1;

      // Nominal stream: lock after the second vsync fall, then checksum frames.
      for (int f = 0; f < 5; f++) begin
         g_act     = vecs[f].act;
         g_chk_pix = vecs[f].chk_pix;
         pulse_cnt = 0;
         run_frame();
         chk($sformatf("f%0d_locked", f), vif.locked, vecs[f].exp_locked);
         chk($sformatf("f%0d_h_period", f), vif.h_period, vecs[f].exp_h);
         chk($sformatf("f%0d_v_period", f), vif.v_period, vecs[f].exp_v);
         chk($sformatf("f%0d_pulses", f), pulse_cnt, vecs[f].exp_pulses);
         chk($sformatf("f%0d_frame_sum", f), vif.frame_sum, vecs[f].exp_sum);
      end
      g_chk_pix = 1'b0;
      chk("blank_err_clean", vif.blank_err, 0);

      // Short line of HT-1 clocks at y=2 while locked.
      g_act = 6'd0;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < ((y == 2) ? HT - 1 : HT); x++) begin
            gen_step(x, y);
            if (y == 3 && x == HSS + 1) chk("short_locked_before", vif.locked, 1);
            if (y == 3 && x == HSS + 2) begin
               chk("short_locked_drop", vif.locked, 0);
               chk("short_h_period", vif.h_period, HT - 1);
            end
            if (y == 4 && x == HSS + 2) chk("short_one_good_line", vif.locked, 0);
         end
      end
      run_frame();
      chk("relock_after_short", vif.locked, 1);
      chk("relock_h_period", vif.h_period, HT);
      chk("relock_v_period", vif.v_period, VT);

      // hsync held high for more than 2*HT clocks: timeout to SEARCH.
      g_hs_force = 1'b1;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < HT; x++)
            gen_step(x, y);
      chk("hs_stuck_locked", vif.locked, 0);
      chk("hs_stuck_h_period", vif.h_period, HT);
      g_hs_force = 1'b0;
      for (int y = 3; y < VT; y++)
         for (int x = 0; x < HT; x++)
            gen_step(x, y);
      chk("hs_stuck_frame_locked", vif.locked, 0);
      chk("hs_stuck_v_period", vif.v_period, 9);
      run_frame();
      chk("hs_stuck_relock", vif.locked, 1);

      // Nonzero colour in horizontal blanking sets the sticky error.
      g_inj_x   = 13;
      g_inj_y   = 2;
      g_inj_rgb = 6'b000001;
      run_frame();
      chk("blank_err_set", vif.blank_err, 1);
      g_inj_x = -1;
      g_inj_y = -1;
      run_frame();
      chk("blank_err_sticky", vif.blank_err, 1);
      chk("blank_err_locked", vif.locked, 1);

      // Reset mid-frame for 3 clocks; partial frame must not produce a checksum.
      g_act = 6'h3F;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            if (y == 3 && x == 4) rst_n = 1'b0;
            if (y == 3 && x == 7) begin
               check_reset_outs();
               rst_n = 1'b1;
               pulse_cnt = 0;
            end
            gen_step(x, y);
         end
      end
      chk("post_rst_locked", vif.locked, 0);
      run_frame();
      chk("post_rst_no_pulse", pulse_cnt, 0);
      chk("post_rst_relock", vif.locked, 1);
      pulse_cnt = 0;
      g_chk_pix = 1'b1;
      run_frame();
      g_chk_pix = 1'b0;
      chk("post_rst_pulse", pulse_cnt, 1);
      chk("post_rst_frame_sum", vif.frame_sum, sum_model(6'h3F));
      chk("post_rst_blank_err", vif.blank_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
